// File: rtl/spi_segment_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_segment_ctrl
// Purpose  : SPI-slave (mode 0) configured controller for one 7-segment
//            display. A host reads/writes four small registers with 16-bit
//            frames. The display shows a hex-decoded digit or raw
//            segments, an optional decimal point, and can blink from a
//            free-running tick prescaler.
// Ports    : clk, rst_n          - system clock, async active-low reset
//            spi_sck/cs_n/mosi   - SPI inputs, asynchronous to clk
//            spi_miso            - SPI read data, MSB first
//            seg_out[6:0]        - segments {g,f,e,d,c,b,a}, registered
//            dp_out              - decimal point, registered
//            frame_ok/frame_err  - one-cycle frame commit/abort pulses
// Revision : 1.0 - initial release
// ============================================================================
module spi_segment_ctrl #(
  parameter logic [23:0] TICK_COUNT  = 24'd10_000_000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic       frame_ok,
  output logic       frame_err
);

  localparam logic [4:0] c_frame_bits = 5'd16;
  localparam logic [4:0] c_byte_bits  = 5'd8;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic        sck_prev_q, sck_prev_d;
  logic        cs_prev_q, cs_prev_d;

  logic        active_q, active_d;      // frame opened by a seen cs_n fall
  logic [15:0] shift_q, shift_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        ovf_q, ovf_d;            // more than 16 clocks in this frame
  logic        rd_q, rd_d;              // read data phase is driving miso
  logic [7:0]  miso_sh_q, miso_sh_d;
  logic        frame_ok_q, frame_ok_d;
  logic        frame_err_q, frame_err_d;

  logic [3:0]  digit_q, digit_d;
  logic [6:0]  raw_q, raw_d;
  logic [2:0]  mode_q, mode_d;
  logic [7:0]  div_q, div_d;

  logic [23:0] presc_q, presc_d;
  logic [7:0]  tick_cnt_q, tick_cnt_d;
  logic        phase_q, phase_d;

  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  // --------------------------------------------------------------------------
  // Combinational wires
  // --------------------------------------------------------------------------
  logic       w_sck_s, w_cs_s, w_mosi_s;
  logic       w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
  logic       w_wr_en;
  logic       w_cfg_wr;
  logic [7:0] w_rd_data;
  logic       w_tick;
  logic       w_blink_on;
  logic [6:0] w_hex;
  logic [6:0] w_pattern;
  logic       w_unused_ok;

  // --------------------------------------------------------------------------
  // Input synchronizers and edge detection
  // --------------------------------------------------------------------------
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    w_sck_s     = sck_sync_q[SYNC_STAGES-1];
    w_cs_s      = cs_sync_q[SYNC_STAGES-1];
    w_mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    sck_prev_d  = w_sck_s;
    cs_prev_d   = w_cs_s;
    w_sck_rise  = w_sck_s & ~sck_prev_q;
    w_sck_fall  = ~w_sck_s & sck_prev_q;
    w_cs_rise   = w_cs_s & ~cs_prev_q;
    w_cs_fall   = ~w_cs_s & cs_prev_q;
  end

  // Readback source, addressed by the last two bits of byte0 as they
  // complete: {previous shifted bit, bit arriving now}.
  always_comb begin
    w_rd_data = 8'h00;
    case ({shift_q[0], w_mosi_s})
      2'd0:    w_rd_data = {4'h0, digit_q};
      2'd1:    w_rd_data = {1'b0, raw_q};
      2'd2:    w_rd_data = {5'h00, mode_q};
      default: w_rd_data = div_q;
    endcase
  end

  // --------------------------------------------------------------------------
  // Frame receiver
  // --------------------------------------------------------------------------
  // active_q only sets on an observed cs_n fall, so a cs_n rise after reset
  // (the synchronizer clears to 0) or a frame cut by reset never commits.
  always_comb begin
    active_d    = active_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    ovf_d       = ovf_q;
    rd_d        = rd_q;
    miso_sh_d   = miso_sh_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    w_wr_en     = 1'b0;

    if (w_cs_fall) begin
      active_d  = 1'b1;
      shift_d   = 16'h0000;
      bit_cnt_d = 5'd0;
      ovf_d     = 1'b0;
      rd_d      = 1'b0;
      miso_sh_d = 8'h00;
    end else if (w_cs_rise) begin
      active_d = 1'b0;
      rd_d     = 1'b0;
      if (active_q) begin
        if ((bit_cnt_q == c_frame_bits) && !ovf_q) begin
          frame_ok_d = 1'b1;
          w_wr_en    = ~shift_q[15];
        end else begin
          frame_err_d = 1'b1;
        end
      end
    end else if (active_q) begin
      if (w_sck_rise) begin
        shift_d = {shift_q[14:0], w_mosi_s};
        if (bit_cnt_q == c_frame_bits) begin
          ovf_d = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
        // Eighth bit arriving completes byte0; its bit7 is shift_q[6] now.
        if ((bit_cnt_q == c_byte_bits - 5'd1) && shift_q[6]) begin
          rd_d      = 1'b1;
          miso_sh_d = w_rd_data;
        end
      end else if (w_sck_fall && rd_q && (bit_cnt_q > c_byte_bits) &&
                   (bit_cnt_q < c_frame_bits)) begin
        // The fall right after bit 8 keeps the MSB up for the host's
        // first byte1 sample; later falls move to the next bit.
        miso_sh_d = {miso_sh_q[6:0], 1'b0};
      end
    end
  end

  // Byte0 bits 6:2 carry no meaning.
  assign w_unused_ok = &{1'b0, shift_q[14:10]};

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  always_comb begin
    digit_d  = digit_q;
    raw_d    = raw_q;
    mode_d   = mode_q;
    div_d    = div_q;
    w_cfg_wr = 1'b0;
    if (w_wr_en) begin
      case (shift_q[9:8])
        2'd0: digit_d = shift_q[3:0];
        2'd1: raw_d   = shift_q[6:0];
        2'd2: begin
          mode_d   = shift_q[2:0];
          w_cfg_wr = 1'b1;
        end
        default: begin
          div_d    = shift_q[7:0];
          w_cfg_wr = 1'b1;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Tick prescaler and blink sequencer
  // --------------------------------------------------------------------------
  always_comb begin
    w_tick  = (presc_q == TICK_COUNT - 24'd1);
    presc_d = w_tick ? 24'd0 : presc_q + 24'd1;
  end

  // Evaluated against the post-write register values so that a tick landing
  // on the commit cycle sees the new configuration.
  always_comb begin
    w_blink_on = mode_d[1] & (div_d != 8'd0);
    tick_cnt_d = tick_cnt_q;
    phase_d    = phase_q;
    if (w_cfg_wr) begin
      tick_cnt_d = 8'd0;
    end
    if (!w_blink_on) begin
      tick_cnt_d = 8'd0;
      phase_d    = 1'b1;
    end else if (w_tick) begin
      if (tick_cnt_d == div_d - 8'd1) begin
        tick_cnt_d = 8'd0;
        phase_d    = ~phase_q;
      end else begin
        tick_cnt_d = tick_cnt_d + 8'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Display path
  // --------------------------------------------------------------------------
  always_comb begin
    w_hex = 7'h00;
    case (digit_q)
      4'h0: w_hex = 7'h3F;
      4'h1: w_hex = 7'h06;
      4'h2: w_hex = 7'h5B;
      4'h3: w_hex = 7'h4F;
      4'h4: w_hex = 7'h66;
      4'h5: w_hex = 7'h6D;
      4'h6: w_hex = 7'h7D;
      4'h7: w_hex = 7'h07;
      4'h8: w_hex = 7'h7F;
      4'h9: w_hex = 7'h6F;
      4'hA: w_hex = 7'h77;
      4'hB: w_hex = 7'h7C;
      4'hC: w_hex = 7'h39;
      4'hD: w_hex = 7'h5E;
      4'hE: w_hex = 7'h79;
      default: w_hex = 7'h71;
    endcase
    w_pattern = mode_q[0] ? raw_q : w_hex;
    seg_d     = phase_q ? w_pattern : 7'h00;
    dp_d      = phase_q & mode_q[2];
  end

  // --------------------------------------------------------------------------
  // Flops
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b0;
      active_q    <= 1'b0;
      shift_q     <= 16'h0000;
      bit_cnt_q   <= 5'd0;
      ovf_q       <= 1'b0;
      rd_q        <= 1'b0;
      miso_sh_q   <= 8'h00;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      digit_q     <= 4'h0;
      raw_q       <= 7'h00;
      mode_q      <= 3'h0;
      div_q       <= 8'd4;
      presc_q     <= 24'd0;
      tick_cnt_q  <= 8'd0;
      phase_q     <= 1'b1;
      seg_q       <= 7'h00;
      dp_q        <= 1'b0;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      cs_prev_q   <= cs_prev_d;
      active_q    <= active_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      ovf_q       <= ovf_d;
      rd_q        <= rd_d;
      miso_sh_q   <= miso_sh_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      digit_q     <= digit_d;
      raw_q       <= raw_d;
      mode_q      <= mode_d;
      div_q       <= div_d;
      presc_q     <= presc_d;
      tick_cnt_q  <= tick_cnt_d;
      phase_q     <= phase_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign spi_miso  = rd_q & miso_sh_q[7];
  assign seg_out   = seg_q;
  assign dp_out    = dp_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_segment_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_segment_ctrl
// Purpose  : Self-checking bench for spi_segment_ctrl: reset values, a table
//            of write/read/aborted frames, blink timing with a short tick,
//            and reset in the middle of a frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_segment_ctrl;

  localparam logic [23:0] TICK_COUNT = 24'd4;

  logic       clk;
  logic       rst_n;
  logic       spi_sck;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic [6:0] seg_out;
  logic       dp_out;
  logic       frame_ok;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  spi_segment_ctrl #(
    .TICK_COUNT  (TICK_COUNT),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_sck   (spi_sck),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .seg_out   (seg_out),
    .dp_out    (dp_out),
    .frame_ok  (frame_ok),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One SPI frame, sck half period = 8 clk. miso is sampled just before each
  // rising sck edge, the way a mode-0 host would. After cs_n rises, watches
  // 12 cycles for commit pulses and records the display on the pulse cycle
  // and the cycle after. With sync_off the cs_n rise waits until the display
  // has just entered its blank phase.
  task automatic spi_frame(input logic [15:0] data, input int nbits, input bit sync_off,
                           output logic [15:0] miso_cap, output int n_ok, output int n_err,
                           output logic [6:0] seg_at, output logic [6:0] seg_after,
                           output logic dp_after);
    bit seen;
    bit got_after;
    miso_cap  = 16'h0000;
    n_ok      = 0;
    n_err     = 0;
    seen      = 1'b0;
    got_after = 1'b0;
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 16) ? data[15-i] : 1'b0;
      repeat (8) @(negedge clk);
      if (i < 16) miso_cap[15-i] = spi_miso;
      spi_sck = 1'b1;
      repeat (8) @(negedge clk);
      spi_sck = 1'b0;
    end
    repeat (8) @(negedge clk);
    if (sync_off) begin
      for (int k = 0; k < 30 && seg_out === 7'h00; k++) @(negedge clk);
      for (int k = 0; k < 30 && seg_out !== 7'h00; k++) @(negedge clk);
    end
    seg_at    = seg_out;
    spi_cs_n  = 1'b1;
    spi_mosi  = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (seen && !got_after) begin
        seg_after = seg_out;
        dp_after  = dp_out;
        got_after = 1'b1;
      end
      if (frame_ok)  n_ok++;
      if (frame_err) n_err++;
      if ((frame_ok || frame_err) && !seen) begin
        seen   = 1'b1;
        seg_at = seg_out;
      end
    end
    if (!got_after) begin
      seg_after = seg_out;
      dp_after  = dp_out;
    end
  endtask

  typedef struct {
    logic [15:0] frame;
    int          nbits;
    int          exp_ok;
    int          exp_err;
    logic [15:0] exp_miso;
    logic [6:0]  exp_seg;
    logic        exp_dp;
  } vec_t;

  vec_t vecs [17];

  logic [15:0] cap;
  int          n_ok, n_err;
  logic [6:0]  s_at, s_after, prev_seg, last;
  logic        d_after, prev_dp;
  int          cnt;

  initial begin
    // frame, bits, ok, err, miso capture, seg after, dp after
    vecs[0]  = '{16'h000A, 16, 1, 0, 16'h0000, 7'h77, 1'b0}; // DIGIT=A
    vecs[1]  = '{16'h8300, 16, 1, 0, 16'h0004, 7'h77, 1'b0}; // read BLINK_DIV reset value
    vecs[2]  = '{16'h0205, 16, 1, 0, 16'h0000, 7'h00, 1'b1}; // MODE raw+dp, RAW=0
    vecs[3]  = '{16'h0149, 16, 1, 0, 16'h0000, 7'h49, 1'b1}; // RAW=49
    vecs[4]  = '{16'h8200, 16, 1, 0, 16'h0005, 7'h49, 1'b1}; // read MODE
    vecs[5]  = '{16'h8100, 16, 1, 0, 16'h0049, 7'h49, 1'b1}; // read RAW
    vecs[6]  = '{16'h8000, 16, 1, 0, 16'h000A, 7'h49, 1'b1}; // read DIGIT
    vecs[7]  = '{16'h0005, 12, 0, 1, 16'h0000, 7'h49, 1'b1}; // short frame
    vecs[8]  = '{16'h0005, 17, 0, 1, 16'h0000, 7'h49, 1'b1}; // long frame
    vecs[9]  = '{16'h8000, 16, 1, 0, 16'h000A, 7'h49, 1'b1}; // DIGIT untouched
    vecs[10] = '{16'h0200, 16, 1, 0, 16'h0000, 7'h77, 1'b0}; // MODE=0 -> hex A
    vecs[11] = '{16'h00F7, 16, 1, 0, 16'h0000, 7'h07, 1'b0}; // upper bits dropped
    vecs[12] = '{16'h80FF, 16, 1, 0, 16'h0007, 7'h07, 1'b0}; // read, byte1 ignored
    vecs[13] = '{16'h02F8, 16, 1, 0, 16'h0000, 7'h07, 1'b0}; // MODE write, bits dropped
    vecs[14] = '{16'h8200, 16, 1, 0, 16'h0000, 7'h07, 1'b0}; // read MODE=0
    vecs[15] = '{16'h0003, 16, 1, 0, 16'h0000, 7'h4F, 1'b0}; // DIGIT=3
    vecs[16] = '{16'h83AA, 16, 1, 0, 16'h0004, 7'h4F, 1'b0}; // BLINK_DIV unchanged

    rst_n    = 1'b0;
    spi_sck  = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;

    // ---------------- reset values ----------------
    repeat (3) @(negedge clk);
    check("rst_seg", 32'(seg_out), 32'h00);
    check("rst_dp", 32'(dp_out), 32'h0);
    check("rst_miso", 32'(spi_miso), 32'h0);
    check("rst_ok", 32'(frame_ok), 32'h0);
    check("rst_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_edge_seg", 32'(seg_out), 32'h3F);
    check("first_edge_dp", 32'(dp_out), 32'h0);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (frame_ok || frame_err) cnt++;
    end
    check("no_pulse_after_reset", 32'(cnt), 32'd0);

    // ---------------- table-driven frames ----------------
    prev_seg = 7'h3F;
    prev_dp  = 1'b0;
    for (int v = 0; v < 17; v++) begin
      spi_frame(vecs[v].frame, vecs[v].nbits, 1'b0, cap, n_ok, n_err, s_at, s_after, d_after);
      check($sformatf("v%0d_ok", v), 32'(n_ok), 32'(vecs[v].exp_ok));
      check($sformatf("v%0d_err", v), 32'(n_err), 32'(vecs[v].exp_err));
      check($sformatf("v%0d_miso", v), 32'(cap), 32'(vecs[v].exp_miso));
      check($sformatf("v%0d_seg_latency", v), 32'(s_at), 32'(prev_seg));
      check($sformatf("v%0d_seg", v), 32'(s_after), 32'(vecs[v].exp_seg));
      check($sformatf("v%0d_dp", v), 32'(d_after), 32'(vecs[v].exp_dp));
      check($sformatf("v%0d_miso_idle", v), 32'(spi_miso), 32'h0);
      prev_seg = vecs[v].exp_seg;
      prev_dp  = vecs[v].exp_dp;
    end

    // ---------------- blinking: TICK_COUNT=4, BLINK_DIV=3 ----------------
    spi_frame(16'h0303, 16, 1'b0, cap, n_ok, n_err, s_at, s_after, d_after);
    check("blink_div_ok", 32'(n_ok), 32'd1);
    spi_frame(16'h0008, 16, 1'b0, cap, n_ok, n_err, s_at, s_after, d_after);
    check("blink_digit_seg", 32'(s_after), 32'h7F);
    spi_frame(16'h0202, 16, 1'b0, cap, n_ok, n_err, s_at, s_after, d_after);
    check("blink_mode_ok", 32'(n_ok), 32'd1);
    last = seg_out;
    cnt  = 0;
    while (seg_out === last && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("blink_started", 32'(cnt < 100), 32'd1);
    for (int p = 0; p < 4; p++) begin
      last = seg_out;
      cnt  = 0;
      while (seg_out === last && cnt < 40) begin
        @(negedge clk);
        cnt++;
      end
      check($sformatf("blink_len%0d", p), 32'(cnt), 32'd12);
      check($sformatf("blink_val%0d", p), 32'(seg_out), (last === 7'h7F) ? 32'h00 : 32'h7F);
      check($sformatf("blink_dp%0d", p), 32'(dp_out), 32'h0);
    end
    // Disable blinking just after the display blanks.
    spi_frame(16'h0200, 16, 1'b1, cap, n_ok, n_err, s_at, s_after, d_after);
    check("unblink_ok", 32'(n_ok), 32'd1);
    check("unblink_seg_at", 32'(s_at), 32'h00);
    check("unblink_seg_after", 32'(s_after), 32'h7F);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (seg_out !== 7'h7F) cnt++;
    end
    check("unblink_steady", 32'(cnt), 32'd0);

    // ---------------- reset in the middle of a frame ----------------
    @(negedge clk);
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      spi_mosi = (i == 7) ? 1'b1 : 1'b0;
      repeat (8) @(negedge clk);
      spi_sck = 1'b1;
      repeat (8) @(negedge clk);
      spi_sck = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst_n    = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_seg", 32'(seg_out), 32'h00);
    check("midrst_dp", 32'(dp_out), 32'h0);
    check("midrst_miso", 32'(spi_miso), 32'h0);
    rst_n = 1'b1;
    cnt   = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (frame_ok || frame_err) cnt++;
    end
    check("midrst_no_pulse", 32'(cnt), 32'd0);
    check("midrst_seg_after", 32'(seg_out), 32'h3F);
    spi_frame(16'h8300, 16, 1'b0, cap, n_ok, n_err, s_at, s_after, d_after);
    check("midrst_div_read", 32'(cap), 32'h0004);
    spi_frame(16'h8200, 16, 1'b0, cap, n_ok, n_err, s_at, s_after, d_after);
    check("midrst_mode_read", 32'(cap), 32'h0000);
    spi_frame(16'h000C, 16, 1'b0, cap, n_ok, n_err, s_at, s_after, d_after);
    check("midrst_write_ok", 32'(n_ok), 32'd1);
    check("midrst_write_err", 32'(n_err), 32'd0);
    check("midrst_write_seg", 32'(s_after), 32'h39);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_segment_ctrl.md
Name: spi_segment_ctrl

Overview:
SPI-slave-configured controller for the single 7-segment display on uo_out. An external host writes and reads a small register file over 16-bit SPI frames. The block sequences what the display shows: a hex-decoded digit or raw segments, an optional decimal point, and timer-driven blinking. It sits between the dedicated I/O pins and the top-level segment outputs.

Parameters:
TICK_COUNT, 24'd10_000_000, number of clk cycles per blink tick (range 2..2^24-1)
SYNC_STAGES, 2, flip-flop depth of the synchronizers on spi_sck, spi_cs_n and spi_mosi (minimum 2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
spi_sck  input  1  SPI clock, mode 0; asynchronous to clk
spi_cs_n  input  1  SPI chip select, active low
spi_mosi  input  1  SPI data in, MSB first
spi_miso  output  1  SPI data out, MSB first
seg_out  output  7  segments {g,f,e,d,c,b,a}, active high, registered
dp_out  output  1  decimal point, active high, registered
frame_ok  output  1  one-cycle pulse when a valid frame commits
frame_err  output  1  one-cycle pulse when a frame is aborted with the wrong bit count

Behaviour:
- Reset: asynchronous and active-low. Every flop clears, including the synchronizers. seg_out=0, dp_out=0, spi_miso=0, frame_ok=0, frame_err=0.
- Register reset values: DIGIT=0, RAW=0, MODE=0, BLINK_DIV=8'd4. Blink phase is ON.
- Clocking: all logic runs on clk. SPI inputs pass through SYNC_STAGES flops before use. Edges are detected on the synchronized sck. Requirement: f_clk >= 8x f_sck.
- Frame format: 16 bits.
  - Byte0: bit7 = R/nW, bits6:2 = 0, bits1:0 = addr.
  - Byte1: write data, ignored on reads.
- Registers:
  - 0 DIGIT[3:0]
  - 1 RAW[6:0]
  - 2 MODE[2:0]: bit0 raw_sel, bit1 blink_en, bit2 dp
  - 3 BLINK_DIV[7:0]
  - Unused write bits are ignored. Unused read bits return 0.
- Shift-in: on each synchronized sck rising edge while cs_n=0, shift mosi into a 16-bit shift register and increment a 5-bit bit counter, saturating at 16.
- Falling edge of cs_n: clear the bit counter and shift register.
- Commit: on the synchronized cs_n rising edge.
  - bit count == 16: frame_ok pulses for 1 cycle. On a write, the register updates on that same cycle. A read has no side effects.
  - bit count != 16 (including more than 16 clocks): frame_err pulses for 1 cycle and no register changes.
- Readback:
  - When bit count reaches 8 and byte0 bit7 = 1, load the addressed register, zero-extended to 8 bits, into the output shifter.
  - spi_miso presents the shifter MSB. The shifter advances on each synchronized sck falling edge during byte1.
  - spi_miso = 0 during byte0, on write frames, and while cs_n = 1.
- Display path (registered, 1-cycle latency from a register or phase change to the outputs):
  - pattern = raw_sel ? RAW : hexdecode(DIGIT).
  - Hex table (gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
  - seg_out = phase_on ? pattern : 0.
  - dp_out = phase_on & MODE.dp.
- Tick prescaler: counts 0..TICK_COUNT-1. A tick pulses for 1 cycle at the wrap. The prescaler is free-running and unaffected by SPI activity.
- Blink sequencer:
  - Active only when blink_en=1 and BLINK_DIV!=0. In that case a tick counter increments on each tick. When it equals BLINK_DIV-1 on a tick, it clears and phase toggles.
  - So each phase lasts BLINK_DIV ticks.
  - If blink_en=0 or BLINK_DIV=0: phase is forced ON and the tick counter is held at 0.
  - A write to MODE or BLINK_DIV clears the tick counter. Phase is left unchanged unless blinking becomes disabled.
- Simultaneous tick and commit: the register write takes effect first, and the tick is evaluated against the new values.
- Reset mid-frame: the partial frame is lost and no frame_ok/frame_err pulses. The next frame needs a fresh cs_n falling edge.

Test Plan:
- Reset release, no SPI activity -> seg_out=7'h00 during reset, 7'h3F one cycle after the first clk edge; dp_out=0; spi_miso=0.
- Write DIGIT=0xA (frame 0x00_0A) -> frame_ok pulse; seg_out=7'h77 one cycle after commit. Then MODE=0x05 and RAW=0x49 -> seg_out=7'h49, dp_out=1.
- Read BLINK_DIV after reset (frame 0x83_00) -> spi_miso shifts 00000100 during byte1; frame_ok pulses; no register changes.
- Aborted frames of 12 and 17 sck cycles writing DIGIT=5 -> frame_err pulses each time; seg_out stays unchanged.
- TICK_COUNT=4, BLINK_DIV=3, MODE=0x02, DIGIT=8 -> seg_out alternates 7'h7F / 7'h00 every 12 clk. Writing MODE=0x00 mid-OFF phase -> seg_out=7'h7F the next cycle.
- Assert rst_n low mid-frame after 9 bits, then release -> all outputs 0 and registers at reset values; a following complete write is accepted normally.
